// File: rtl/czono_pkg.sv
// Shared encodings for the constrained-zonotope intersection sequencer.
// Holds command field/source codes, FSM and phase enums, and index-width helper.
// Imported by the sequencer top and its row/column counter.
package czono_pkg;

    // Index width wide enough for the largest destination row (2*NCMAX+NRMAX).
    function automatic int idx_w_f(input int ncmax, input int nrmax);
        return $clog2(2 * ncmax + nrmax + 1);
    endfunction

    // Destination field of an element-write command.
    localparam logic [1:0] FIELD_C = 2'd0;
    localparam logic [1:0] FIELD_G = 2'd1;
    localparam logic [1:0] FIELD_A = 2'd2;
    localparam logic [1:0] FIELD_B = 2'd3;

    // Source operand selected by the OUT assembly datapath.
    localparam logic [2:0] SRC_ZERO     = 3'd0;
    localparam logic [2:0] SRC_Z        = 3'd1;
    localparam logic [2:0] SRC_Y        = 3'd2;
    localparam logic [2:0] SRC_RZ       = 3'd3;
    localparam logic [2:0] SRC_NEG_Y    = 3'd4;
    localparam logic [2:0] SRC_SUB_Y_RZ = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_EMIT,
        ST_WAIT_LI,
        ST_DONE
    } state_t;

    // Emission phases in output order; AR/BR need the linear_image result.
    typedef enum logic [3:0] {
        PH_C   = 4'd0,
        PH_G   = 4'd1,
        PH_AZ  = 4'd2,
        PH_AY  = 4'd3,
        PH_BZ  = 4'd4,
        PH_BY  = 4'd5,
        PH_AR  = 4'd6,
        PH_BR  = 4'd7,
        PH_END = 4'd8
    } phase_t;

endpackage

// File: rtl/czono_idx_ctr.sv
// Two-level row/column counter; column is the inner loop, limits supplied live.
// Zero latency: o_last reflects the current position combinationally.
// Advances only when i_en is high; i_clr wins over i_en and returns to (0,0).
module czono_idx_ctr
    import czono_pkg::*;
#(
    parameter int W = 11
)(
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_rows,
    input  logic [W-1:0] i_cols,
    output logic [W-1:0] o_row,
    output logic [W-1:0] o_col,
    output logic         o_last
);

    logic [W-1:0] r_row;
    logic [W-1:0] r_col;
    logic [W-1:0] w_row_max;
    logic [W-1:0] w_col_max;
    logic         w_col_wrap;

    assign w_row_max  = i_rows - W'(1);
    assign w_col_max  = i_cols - W'(1);
    assign w_col_wrap = (r_col == w_col_max);

    // Step the column, wrapping into the next row at the column limit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_en) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + W'(1);
            end else begin
                r_col <= r_col + W'(1);
            end
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = (r_row == w_row_max) && w_col_wrap;

endmodule

// File: rtl/czono_intersect_seq.sv
// Sequences OUT = Z intersect_R Y: checks dims, launches linear_image, emits element writes.
// Error reported 2 cycles after start; commands 1/cycle from the cycle li_start_o pulses.
// Valid/ready on commands: fields hold while stalled; RZ phases stall until li_done seen.
module czono_intersect_seq
    import czono_pkg::*;
#(
    parameter int NMAX  = 512,
    parameter int NGMAX = 512,
    parameter int NCMAX = 512,
    parameter int NRMAX = 512,
    parameter int IDX_W = idx_w_f(NCMAX, NRMAX)
)(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [IDX_W-1:0] zn_i,
    input  logic [IDX_W-1:0] zng_i,
    input  logic [IDX_W-1:0] znc_i,
    input  logic [IDX_W-1:0] yn_i,
    input  logic [IDX_W-1:0] yng_i,
    input  logic [IDX_W-1:0] ync_i,
    input  logic [IDX_W-1:0] rnr_i,
    input  logic [IDX_W-1:0] rnc_i,
    output logic             li_start_o,
    input  logic             li_done_i,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [1:0]       cmd_field_o,
    output logic [IDX_W-1:0] cmd_row_o,
    output logic [IDX_W-1:0] cmd_col_o,
    output logic [2:0]       cmd_src_o,
    output logic [IDX_W-1:0] cmd_srow_o,
    output logic [IDX_W-1:0] cmd_scol_o,
    output logic [IDX_W-1:0] out_n_o,
    output logic [IDX_W-1:0] out_ng_o,
    output logic [IDX_W-1:0] out_nc_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    // Three-term constraint sum needs two guard bits to stay wrap-free.
    localparam logic [IDX_W:0]   LIM_NG = (IDX_W + 1)'(NGMAX);
    localparam logic [IDX_W+1:0] LIM_NC = (IDX_W + 2)'(NCMAX);
    localparam logic [IDX_W-1:0] LIM_N  = IDX_W'(NMAX);
    localparam logic [IDX_W-1:0] LIM_R  = IDX_W'(NRMAX);

    state_t           r_state, w_state_nxt;
    phase_t           r_phase, w_phase_nxt, w_nxt_phase;

    logic [IDX_W-1:0] r_zn, r_zng, r_znc, r_yn, r_yng, r_ync, r_rnr, r_rnc;
    logic [IDX_W-1:0] r_out_n, r_out_ng, r_out_nc;
    logic             r_err;
    logic             r_li_start;
    logic             r_li_armed;
    logic             r_li_done;

    logic [IDX_W:0]   w_sum_ng;
    logic [IDX_W+1:0] w_sum_nc;
    logic             w_chk_err;
    logic             w_li_ok;
    logic             w_valid;
    logic             w_fire;
    logic             w_dep_nxt;

    logic [IDX_W-1:0] w_rows [8];
    logic [IDX_W-1:0] w_cols [8];
    logic [7:0]       w_nonempty;

    logic             w_ctr_clr, w_ctr_en, w_ctr_last;
    logic [IDX_W-1:0] w_ctr_row, w_ctr_col;

    logic [1:0]       w_field;
    logic [2:0]       w_src;
    logic [IDX_W-1:0] w_row, w_col, w_srow, w_scol;
    logic             w_zsel;
    logic [IDX_W-1:0] w_ycol;

    // Dimension check, evaluated on the latched operands during CHECK.
    assign w_sum_ng  = {1'b0, r_zng} + {1'b0, r_yng};
    assign w_sum_nc  = {2'b00, r_znc} + {2'b00, r_ync} + {2'b00, r_rnr};
    assign w_chk_err = (r_zn == '0) || (r_yn != r_rnr) || (r_rnc != r_zn) ||
                       (w_sum_ng > LIM_NG) || (w_sum_nc > LIM_NC) ||
                       (r_zn > LIM_N) || (r_rnr > LIM_R);

    // A li_done arriving this cycle counts immediately so AR follows without an extra bubble.
    assign w_li_ok = r_li_done || (r_li_armed && li_done_i);
    assign w_valid = (r_state == ST_EMIT);
    assign w_fire  = w_valid && cmd_ready_i;

    // Per-phase loop bounds and which phases actually produce commands.
    always_comb begin
        w_rows[0] = r_zn;   w_cols[0] = IDX_W'(1);
        w_rows[1] = r_zn;   w_cols[1] = r_out_ng;
        w_rows[2] = r_znc;  w_cols[2] = r_out_ng;
        w_rows[3] = r_ync;  w_cols[3] = r_out_ng;
        w_rows[4] = r_znc;  w_cols[4] = IDX_W'(1);
        w_rows[5] = r_ync;  w_cols[5] = IDX_W'(1);
        w_rows[6] = r_rnr;  w_cols[6] = r_out_ng;
        w_rows[7] = r_rnr;  w_cols[7] = IDX_W'(1);
        for (int p = 0; p < 8; p++) begin
            w_nonempty[p] = (w_rows[p] != '0) && (w_cols[p] != '0);
        end
    end

    // First non-empty phase after the current one, or PH_END.
    always_comb begin
        w_nxt_phase = PH_END;
        for (int p = 7; p >= 0; p--) begin
            if ((p > int'(r_phase)) && w_nonempty[p]) begin
                w_nxt_phase = phase_t'(4'(p));
            end
        end
    end

    assign w_dep_nxt = (w_nxt_phase == PH_AR) || (w_nxt_phase == PH_BR) ||
                       (w_nxt_phase == PH_END);

    czono_idx_ctr #(
        .W (IDX_W)
    ) u_ctr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .i_clr  (w_ctr_clr),
        .i_en   (w_ctr_en),
        .i_rows (w_rows[r_phase[2:0]]),
        .i_cols (w_cols[r_phase[2:0]]),
        .o_row  (w_ctr_row),
        .o_col  (w_ctr_col),
        .o_last (w_ctr_last)
    );

    // Next-state logic: phase hand-off happens on the last handshake of a phase.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_ctr_clr   = 1'b0;
        w_ctr_en    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start_i) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_ctr_clr = 1'b1;
                if (w_chk_err) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_EMIT;
                    w_phase_nxt = PH_C;
                end
            end
            ST_EMIT: begin
                if (w_fire) begin
                    if (w_ctr_last) begin
                        w_ctr_clr   = 1'b1;
                        w_phase_nxt = w_nxt_phase;
                        if (w_dep_nxt && !w_li_ok)       w_state_nxt = ST_WAIT_LI;
                        else if (w_nxt_phase == PH_END)  w_state_nxt = ST_DONE;
                    end else begin
                        w_ctr_en = 1'b1;
                    end
                end
            end
            ST_WAIT_LI: begin
                if (w_li_ok) begin
                    w_state_nxt = (r_phase == PH_END) ? ST_DONE : ST_EMIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, phase and operand/result registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_phase    <= PH_C;
            r_zn       <= '0;
            r_zng      <= '0;
            r_znc      <= '0;
            r_yn       <= '0;
            r_yng      <= '0;
            r_ync      <= '0;
            r_rnr      <= '0;
            r_rnc      <= '0;
            r_out_n    <= '0;
            r_out_ng   <= '0;
            r_out_nc   <= '0;
            r_err      <= 1'b0;
            r_li_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_li_start <= (r_state == ST_CHECK) && !w_chk_err;
            if ((r_state == ST_IDLE) && start_i) begin
                r_zn  <= zn_i;
                r_zng <= zng_i;
                r_znc <= znc_i;
                r_yn  <= yn_i;
                r_yng <= yng_i;
                r_ync <= ync_i;
                r_rnr <= rnr_i;
                r_rnc <= rnc_i;
            end
            if (r_state == ST_CHECK) begin
                r_err <= w_chk_err;
                if (!w_chk_err) begin
                    r_out_n  <= r_zn;
                    r_out_ng <= w_sum_ng[IDX_W-1:0];
                    r_out_nc <= w_sum_nc[IDX_W-1:0];
                end
            end
        end
    end

    // li_done latch: armed from the cycle after li_start_o, cleared for each new operation.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_li_armed <= 1'b0;
            r_li_done  <= 1'b0;
        end else if (r_state == ST_CHECK) begin
            r_li_armed <= 1'b0;
            r_li_done  <= 1'b0;
        end else begin
            if (r_li_start)              r_li_armed <= 1'b1;
            if (r_li_armed && li_done_i) r_li_done  <= 1'b1;
        end
    end

    // Command decode from phase and counter position.
    always_comb begin
        w_field = FIELD_C;
        w_row   = '0;
        w_col   = '0;
        w_src   = SRC_ZERO;
        w_srow  = '0;
        w_scol  = '0;
        w_zsel  = (w_ctr_col < r_zng);
        w_ycol  = w_ctr_col - r_zng;
        unique case (r_phase)
            PH_C: begin
                w_field = FIELD_C;
                w_row   = w_ctr_row;
                w_src   = SRC_Z;
                w_srow  = w_ctr_row;
            end
            PH_G, PH_AZ: begin
                w_field = (r_phase == PH_G) ? FIELD_G : FIELD_A;
                w_row   = w_ctr_row;
                w_col   = w_ctr_col;
                if (w_zsel) begin
                    w_src  = SRC_Z;
                    w_srow = w_ctr_row;
                    w_scol = w_ctr_col;
                end
            end
            PH_AY: begin
                w_field = FIELD_A;
                w_row   = r_znc + w_ctr_row;
                w_col   = w_ctr_col;
                if (!w_zsel) begin
                    w_src  = SRC_Y;
                    w_srow = w_ctr_row;
                    w_scol = w_ycol;
                end
            end
            PH_BZ: begin
                w_field = FIELD_B;
                w_row   = w_ctr_row;
                w_src   = SRC_Z;
                w_srow  = w_ctr_row;
            end
            PH_BY: begin
                w_field = FIELD_B;
                w_row   = r_znc + w_ctr_row;
                w_src   = SRC_Y;
                w_srow  = w_ctr_row;
            end
            PH_AR: begin
                w_field = FIELD_A;
                w_row   = r_znc + r_ync + w_ctr_row;
                w_col   = w_ctr_col;
                w_srow  = w_ctr_row;
                w_src   = w_zsel ? SRC_RZ : SRC_NEG_Y;
                w_scol  = w_zsel ? w_ctr_col : w_ycol;
            end
            PH_BR: begin
                w_field = FIELD_B;
                w_row   = r_znc + r_ync + w_ctr_row;
                w_src   = SRC_SUB_Y_RZ;
                w_srow  = w_ctr_row;
            end
            default: begin
                w_field = FIELD_C;
            end
        endcase
    end

    // Command fields are forced to zero whenever no command is offered.
    assign cmd_valid_o = w_valid;
    assign cmd_field_o = w_valid ? w_field : '0;
    assign cmd_row_o   = w_valid ? w_row   : '0;
    assign cmd_col_o   = w_valid ? w_col   : '0;
    assign cmd_src_o   = w_valid ? w_src   : '0;
    assign cmd_srow_o  = w_valid ? w_srow  : '0;
    assign cmd_scol_o  = w_valid ? w_scol  : '0;

    assign li_start_o  = r_li_start;
    assign out_n_o     = r_out_n;
    assign out_ng_o    = r_out_ng;
    assign out_nc_o    = r_out_nc;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_DONE);
    assign err_o       = (r_state == ST_DONE) && r_err;

endmodule

// File: tb/tb_czono_intersect_seq.sv
// Randomised scoreboard bench for czono_intersect_seq against a loop-based reference model.
module tb_czono_intersect_seq;
    import czono_pkg::*;

    localparam int W = 11;

    logic         clk_i = 1'b0;
    logic         rstn_i = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] zn_i = '0, zng_i = '0, znc_i = '0, yn_i = '0;
    logic [W-1:0] yng_i = '0, ync_i = '0, rnr_i = '0, rnc_i = '0;
    logic         li_start_o;
    logic         li_done_i = 1'b0;
    logic         cmd_valid_o;
    logic         cmd_ready_i = 1'b1;
    logic [1:0]   cmd_field_o;
    logic [W-1:0] cmd_row_o, cmd_col_o, cmd_srow_o, cmd_scol_o;
    logic [2:0]   cmd_src_o;
    logic [W-1:0] out_n_o, out_ng_o, out_nc_o;
    logic         busy_o, done_o, err_o;

    czono_intersect_seq dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
        .zn_i(zn_i), .zng_i(zng_i), .znc_i(znc_i),
        .yn_i(yn_i), .yng_i(yng_i), .ync_i(ync_i),
        .rnr_i(rnr_i), .rnc_i(rnc_i),
        .li_start_o(li_start_o), .li_done_i(li_done_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_field_o(cmd_field_o), .cmd_row_o(cmd_row_o), .cmd_col_o(cmd_col_o),
        .cmd_src_o(cmd_src_o), .cmd_srow_o(cmd_srow_o), .cmd_scol_o(cmd_scol_o),
        .out_n_o(out_n_o), .out_ng_o(out_ng_o), .out_nc_o(out_nc_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] f;
        int         row, col;
        logic [2:0] src;
        int         srow, scol;
        bit         first;
        bit         first_dep;
    } cmd_t;

    typedef struct {
        bit err;
        bit chk_lat;
        int n, ng, nc;
    } done_t;

    cmd_t  exp_q[$];
    done_t done_q[$];

    int total = 0, bad = 0;
    int cyc = 0;
    int n_fire = 0, n_done = 0, n_li_start = 0;
    int exp_li_starts = 0, exp_dones = 0, exp_cnt = 0;
    int last_fire_cyc = -10, li_start_cyc = -10, li_done_cyc = -10, start_cyc = -10;
    int li_delay = 3, li_due = -100;
    bit rnd_ready = 1'b0, full_rate = 1'b1, late_chk = 1'b0;
    bit mdl_first, mdl_dep_seen;
    bit stalled = 1'b0;
    logic [48:0] saved_cmd, cur_cmd;
    cmd_t  e;
    done_t d;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_cmd(input logic [1:0] f, input int row, input int col,
                            input logic [2:0] src, input int srow, input int scol, input bit dep);
        cmd_t c;
        c.f = f; c.row = row; c.col = col; c.src = src; c.srow = srow; c.scol = scol;
        c.first = mdl_first;
        c.first_dep = dep && !mdl_dep_seen;
        mdl_first = 1'b0;
        if (dep) mdl_dep_seen = 1'b1;
        exp_q.push_back(c);
        exp_cnt++;
    endtask

    task automatic push_model(input int zn, input int zng, input int znc, input int yn,
                              input int yng, input int ync, input int rnr, input int rnc);
        done_t dd;
        int ng, nc;
        bit err;
        err = (zn == 0) || (yn != rnr) || (rnc != zn) || (zng + yng > 512) ||
              (znc + ync + rnr > 512) || (zn > 512) || (rnr > 512);
        ng = zng + yng;
        nc = znc + ync + rnr;
        exp_cnt = 0;
        dd.err = err; dd.chk_lat = (rnr > 0); dd.n = zn; dd.ng = ng; dd.nc = nc;
        done_q.push_back(dd);
        exp_dones++;
        if (err) return;
        exp_li_starts++;
        mdl_first = 1'b1;
        mdl_dep_seen = 1'b0;
        for (int i = 0; i < zn; i++) push_cmd(FIELD_C, i, 0, SRC_Z, i, 0, 0);
        for (int i = 0; i < zn; i++)
            for (int j = 0; j < ng; j++)
                push_cmd(FIELD_G, i, j, (j < zng) ? SRC_Z : SRC_ZERO, i, j, 0);
        for (int i = 0; i < znc; i++)
            for (int j = 0; j < ng; j++)
                push_cmd(FIELD_A, i, j, (j < zng) ? SRC_Z : SRC_ZERO, i, j, 0);
        for (int i = 0; i < ync; i++)
            for (int j = 0; j < ng; j++)
                push_cmd(FIELD_A, znc + i, j, (j < zng) ? SRC_ZERO : SRC_Y, i, j - zng, 0);
        for (int i = 0; i < znc; i++) push_cmd(FIELD_B, i, 0, SRC_Z, i, 0, 0);
        for (int i = 0; i < ync; i++) push_cmd(FIELD_B, znc + i, 0, SRC_Y, i, 0, 0);
        for (int i = 0; i < rnr; i++)
            for (int j = 0; j < ng; j++)
                push_cmd(FIELD_A, znc + ync + i, j, (j < zng) ? SRC_RZ : SRC_NEG_Y,
                         i, (j < zng) ? j : j - zng, 1);
        for (int i = 0; i < rnr; i++) push_cmd(FIELD_B, znc + ync + i, 0, SRC_SUB_Y_RZ, i, 0, 1);
    endtask

    // ---------------- environment drivers ----------------
    always @(posedge clk_i) begin
        #1;
        li_done_i   = (cyc == li_due);
        cmd_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            stalled = 1'b0;
        end else begin
            cur_cmd = {cmd_field_o, cmd_row_o, cmd_col_o, cmd_src_o, cmd_srow_o, cmd_scol_o};
            if (li_done_i) li_done_cyc = cyc;
            if (li_start_o) begin
                n_li_start++;
                li_start_cyc = cyc;
                li_due = cyc + li_delay;
            end
            if (stalled) begin
                chk("stall_valid", cmd_valid_o, 1);
                chk("stall_hold", cur_cmd, saved_cmd);
            end
            stalled   = cmd_valid_o && !cmd_ready_i;
            saved_cmd = cur_cmd;
            if (cmd_valid_o && cmd_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_cmd: got field=%0d row=%0d col=%0d expected none",
                             cmd_field_o, cmd_row_o, cmd_col_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("cmd_field", cmd_field_o, e.f);
                    chk("cmd_row", cmd_row_o, e.row);
                    chk("cmd_col", cmd_col_o, e.col);
                    chk("cmd_src", cmd_src_o, e.src);
                    if (e.src != SRC_ZERO) begin
                        chk("cmd_srow", cmd_srow_o, e.srow);
                        chk("cmd_scol", cmd_scol_o, e.scol);
                    end
                    if (full_rate) begin
                        if (e.first) chk("first_cmd_cyc", cyc, li_start_cyc);
                        else if (e.first_dep && late_chk) chk("late_ar_cyc", cyc, li_done_cyc + 1);
                        else chk("no_bubble", cyc, last_fire_cyc + 1);
                    end
                end
                last_fire_cyc = cyc;
                n_fire++;
            end
            if (err_o && !done_o) chk("err_without_done", err_o, 0);
            if (done_o) begin
                n_done++;
                if (done_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    d = done_q.pop_front();
                    chk("err", err_o, d.err);
                    if (d.err) begin
                        chk("err_latency", cyc, start_cyc + 2);
                    end else begin
                        if (d.chk_lat) chk("done_latency", cyc, last_fire_cyc + 1);
                        chk("out_n", out_n_o, d.n);
                        chk("out_ng", out_ng_o, d.ng);
                        chk("out_nc", out_nc_o, d.nc);
                        chk("cmds_left", exp_q.size(), 0);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_op(input int zn, input int zng, input int znc, input int yn,
                            input int yng, input int ync, input int rnr, input int rnc);
        for (int k = 0; k < 300 && busy_o; k++) @(posedge clk_i);
        if (busy_o) begin
            total++; bad++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        @(posedge clk_i);
        #1;
        zn_i = W'(zn); zng_i = W'(zng); znc_i = W'(znc); yn_i = W'(yn);
        yng_i = W'(yng); ync_i = W'(ync); rnr_i = W'(rnr); rnc_i = W'(rnc);
        push_model(zn, zng, znc, yn, yng, ync, rnr, rnc);
        start_i = 1'b1;
        start_cyc = cyc;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        n0 = n_done;
        for (int k = 0; k < budget && n_done == n0; k++) @(posedge clk_i);
        if (n_done == n0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
            exp_dones -= done_q.size();
            exp_q.delete();
            done_q.delete();
        end
        @(posedge clk_i);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valid"}, cmd_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_pulses"}, {li_start_o, done_o, err_o}, 0);
        chk({tag, "_dims"}, {out_n_o, out_ng_o, out_nc_o}, 0);
        chk({tag, "_cmd"}, {cmd_field_o, cmd_row_o, cmd_col_o, cmd_src_o, cmd_srow_o, cmd_scol_o}, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int f0;
        repeat (3) @(posedge clk_i);
        #1;
        check_quiet("reset");
        rstn_i = 1'b1;

        // Nominal run, plus a start pulse with junk dims while busy that must be ignored.
        li_delay = 3; rnd_ready = 0; full_rate = 1; late_chk = 0;
        f0 = n_fire;
        start_op(2, 3, 1, 2, 2, 1, 2, 2);
        repeat (6) @(posedge clk_i);
        #1;
        zn_i = 5; zng_i = 1; rnr_i = 7; start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(500);
        chk("nominal_count", n_fire - f0, 36);

        // Late linear_image completion.
        li_delay = 50; late_chk = 1;
        f0 = n_fire;
        start_op(2, 3, 1, 2, 2, 1, 2, 2);
        wait_done(500);
        chk("late_count", n_fire - f0, 36);

        // Random backpressure.
        li_delay = 3; late_chk = 0; rnd_ready = 1; full_rate = 0;
        f0 = n_fire;
        start_op(2, 3, 1, 2, 2, 1, 2, 2);
        wait_done(1000);
        chk("bp_count", n_fire - f0, 36);

        // Dimension error: yn != rnr.
        rnd_ready = 0; full_rate = 1;
        f0 = n_fire;
        start_op(2, 3, 1, 3, 2, 1, 2, 2);
        wait_done(50);
        chk("err_no_cmds", n_fire - f0, 0);

        // No constraints from Z or Y: A/B phases of Z and Y skipped.
        f0 = n_fire;
        start_op(2, 3, 0, 2, 1, 0, 2, 2);
        wait_done(500);
        chk("nc0_count", n_fire - f0, exp_cnt);
        chk("nc0_count_abs", n_fire - f0, 20);

        // Random operands, random ready and linear_image latency.
        full_rate = 0;
        for (int t = 0; t < 8; t++) begin
            int zn, rnr, rnc;
            zn  = $urandom_range(1, 3);
            rnr = $urandom_range(0, 3);
            rnc = ($urandom_range(0, 9) == 0) ? zn + 1 : zn;
            rnd_ready = 1'($urandom_range(0, 1));
            li_delay  = $urandom_range(1, 40);
            start_op(zn, $urandom_range(0, 3), $urandom_range(0, 2), rnr,
                     $urandom_range(0, 3), $urandom_range(0, 2), rnr, rnc);
            wait_done(1500);
        end

        // Reset in the middle of AR, then a full second run with a late li_done.
        rnd_ready = 0; full_rate = 1; late_chk = 0; li_delay = 3;
        f0 = n_fire;
        start_op(2, 3, 1, 2, 2, 1, 2, 2);
        for (int k = 0; k < 200 && (n_fire - f0) < 27; k++) @(posedge clk_i);
        chk("reached_ar", (n_fire - f0) >= 27, 1);
        #2;
        rstn_i = 1'b0;
        #1;
        check_quiet("midreset");
        exp_dones -= done_q.size();
        exp_q.delete();
        done_q.delete();
        li_due = -100;
        repeat (3) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        li_delay = 40; late_chk = 1;
        f0 = n_fire;
        start_op(2, 3, 1, 2, 2, 1, 2, 2);
        wait_done(500);
        chk("after_reset_count", n_fire - f0, 36);

        repeat (3) @(posedge clk_i);
        chk("li_start_total", n_li_start, exp_li_starts);
        chk("done_total", n_done, exp_dones);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
